ahb_sram_ctrl_p: RTL

Parametrised AHB-Lite slave that fronts a single-port synchronous SRAM (sram: 1-cycle read, active-low cs_n/w_en) and supersedes the fixed 32-bit controller. It adds configurable data width, depth and read wait states, per-byte write strobes, and AHB ERROR responses for illegal transfers. It sits between the AHB fabric and one sram instance.

---
 rtl/ahb_sram_pkg.sv | 27 ++
 rtl/ahb_sram_ctrl_p_if.sv | 30 +++
 rtl/ahb_sram_lane_dec.sv | 31 +++
 rtl/ahb_sram_ctrl_p.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ahb_sram_pkg.sv
// Shared AHB-Lite encodings and FSM state type
// for the parametrised SRAM controller.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HALF  = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RDW,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahb_sram_ctrl_p_if.sv
// AHB-Lite slave-side bus bundle with
// master and slave views.
interface ahb_sram_ctrl_p_if #(
  parameter int DATA_WIDTH = 32
);

  logic                  hsel;
  logic                  hwrite;
  logic [1:0]            htrans;
  logic [2:0]            hsize;
  logic [2:0]            hburst;
  logic [31:0]           haddr;
  logic [DATA_WIDTH-1:0] hwdata;
  logic                  hready;
  logic [1:0]            hresp;
  logic [DATA_WIDTH-1:0] hrdata;

  modport master (
    output hsel, hwrite, htrans, hsize,
    output hburst, haddr, hwdata,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  hsel, hwrite, htrans, hsize,
    input  hburst, haddr, hwdata,
    output hready, hresp, hrdata
  );

endinterface

// File: rtl/ahb_sram_lane_dec.sv
// Byte-lane mask and legality decode for
// one AHB transfer within a bus word.
module ahb_sram_lane_dec #(
  parameter  int DATA_WIDTH = 32,
  localparam int NB  = DATA_WIDTH / 8,
  localparam int OFF = $clog2(NB)
) (
  input  logic [2:0]     size_i,
  input  logic [OFF-1:0] addr_i,
  output logic [NB-1:0]  mask_o,
  output logic           bad_o
);

  logic [NB-1:0]  span;
  logic [OFF-1:0] align;

  always_comb begin
    span  = '0;
    align = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < (1 << size_i)) span[i] = 1'b1;
    end
    for (int i = 0; i < OFF; i++) begin
      if (i < int'(size_i)) align[i] = 1'b1;
    end
    mask_o = span << addr_i;
    bad_o  = (int'(size_i) > OFF) ||
             (|(addr_i & align));
  end

endmodule

// File: rtl/ahb_sram_ctrl_p.sv
// AHB-Lite slave fronting a single-port sync
// SRAM with byte strobes and read wait states.
module ahb_sram_ctrl_p
  import ahb_sram_pkg::*;
#(
  parameter  int DATA_WIDTH  = 32,
  parameter  int ADDR_WIDTH  = 12,
  parameter  int WAIT_STATES = 0,
  localparam int NB  = DATA_WIDTH / 8,
  localparam int OFF = $clog2(NB)
) (
  input  logic                  hclk,
  input  logic                  hreset,
  ahb_sram_ctrl_p_if.slave      ahb,
  output logic                  sram_csn,
  output logic                  sram_wen,
  output logic [NB-1:0]         sram_ben,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  state_e                state_q;
  state_e                acc_st;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [NB-1:0]         mask_q;
  logic [2:0]            cnt_q;
  logic [DATA_WIDTH-1:0] buf_q;
  logic [DATA_WIDTH-1:0] hrdata_q;

  logic                  acc;
  logic                  bad_lane;
  logic                  bad_range;
  logic                  rd_last;
  logic [NB-1:0]         mask;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_ok;

  ahb_sram_lane_dec #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dec (
    .size_i (ahb.hsize),
    .addr_i (ahb.haddr[OFF-1:0]),
    .mask_o (mask),
    .bad_o  (bad_lane)
  );

  assign unused_ok = ^{ahb.hburst, ahb.htrans[0]};

  assign acc = ahb.hsel & ahb.htrans[1] &
               ahb.hready;
  assign bad_range =
    |ahb.haddr[31:ADDR_WIDTH+OFF];

  always_comb begin
    acc_st = ST_IDLE;
    if (acc) begin
      if (bad_lane || bad_range)
        acc_st = ST_ERR1;
      else if (ahb.hwrite)
        acc_st = ST_WR;
      else
        acc_st = ST_RD;
    end
  end

  // With wait states the SRAM output is
  // parked in buf_q one cycle after the strobe.
  assign rd_word = (WAIT_STATES == 0) ?
                   sram_q : buf_q;
  assign rd_last = (state_q == ST_RDW) &&
                   (cnt_q == 3'(WAIT_STATES));

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      mask_q   <= '0;
      cnt_q    <= '0;
      buf_q    <= '0;
      hrdata_q <= '0;
    end else begin
      unique case (state_q)
        ST_RD: begin
          state_q <= ST_RDW;
          cnt_q   <= '0;
        end
        ST_RDW: begin
          if (cnt_q == 3'd0) buf_q <= sram_q;
          if (rd_last) begin
            hrdata_q <= rd_word;
            state_q  <= acc_st;
          end else begin
            cnt_q <= cnt_q + 3'd1;
          end
        end
        ST_ERR1: state_q <= ST_ERR2;
        default: state_q <= acc_st;
      endcase
      if (acc) begin
        addr_q <= ahb.haddr[ADDR_WIDTH+OFF-1:OFF];
        mask_q <= mask;
      end
    end
  end

  assign ahb.hready =
    !((state_q == ST_RD) ||
      (state_q == ST_ERR1) ||
      ((state_q == ST_RDW) && !rd_last));

  assign ahb.hresp =
    ((state_q == ST_ERR1) ||
     (state_q == ST_ERR2)) ?
    HRESP_ERROR : HRESP_OKAY;

  assign ahb.hrdata = rd_last ? rd_word : hrdata_q;

  assign sram_csn = !((state_q == ST_WR) ||
                      (state_q == ST_RD));
  assign sram_wen = (state_q != ST_WR);
  assign sram_ben = (state_q == ST_WR) ?
                    ~mask_q : '1;
  assign sram_a   = sram_csn ? '0 : addr_q;
  assign sram_d   = (state_q == ST_WR) ?
                    ahb.hwdata : '0;

endmodule
